// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer: FSM states, the
// registered output bundle and the timer width calculation.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } seq_state_e;

  typedef struct packed {
    logic pll_rst;
    logic core_rst;
    logic ready;
    logic fail;
  } seq_out_t;

  // One timer serves every state, so size it for the longest interval.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

  function automatic seq_out_t dec_outs(input seq_state_e s);
    seq_out_t o;
    o.pll_rst  = (s == PLL_RST);
    o.core_rst = (s != RUN);
    o.ready    = (s == RUN);
    o.fail     = (s == FAIL);
    return o;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL control pair: reset into the PLL, lock status back out of it.
interface pll_reset_sequencer_if;
  logic pll_rst;
  logic pll_locked;

  modport master (output pll_rst, input pll_locked);
  modport slave  (input pll_rst, output pll_locked);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous status bits, cleared by reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for a continuously stable lock before releasing
// core reset, retries on lock timeout and re-arms the PLL on lock loss.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE    = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 7,
  parameter int CNT_W        = 8
) (
  input  logic                     clk_sys,
  input  logic                     rst,
  pll_reset_sequencer_if.master    pll,
  output logic                     core_rst,
  output logic                     ready,
  output logic                     fail,
  output logic [CNT_W-1:0]         retry_cnt,
  output logic [CNT_W-1:0]         loss_cnt
);

  localparam int TW = tmr_width(RST_PULSE, LOCK_TIMEOUT, LOCK_STABLE);
  localparam logic [TW-1:0]    RP_END  = TW'(RST_PULSE - 1);
  localparam logic [TW-1:0]    LT_END  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]    LS_END  = TW'(LOCK_STABLE - 1);
  localparam logic [7:0]       MR      = 8'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_e    state;
  seq_out_t      outs;
  logic [TW-1:0] tmr;
  logic [7:0]    attempts;
  logic          lk;

  sync_2ff #(.W(1)) u_lk_sync (
    .clk (clk_sys),
    .rst (rst),
    .d   (pll.pll_locked),
    .q   (lk)
  );

  // Outputs are registered alongside the state so they change on the same edge.
  assign pll.pll_rst = outs.pll_rst;
  assign core_rst    = outs.core_rst;
  assign ready       = outs.ready;
  assign fail        = outs.fail;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state     <= PLL_RST;
      outs      <= dec_outs(PLL_RST);
      tmr       <= '0;
      attempts  <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      tmr <= tmr + 1'b1;
      unique case (state)
        PLL_RST: begin
          if (tmr == RP_END) begin
            state <= WAIT_LOCK;
            outs  <= dec_outs(WAIT_LOCK);
            tmr   <= '0;
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority over a coincident timeout.
          if (lk) begin
            state <= STABLE;
            outs  <= dec_outs(STABLE);
            tmr   <= '0;
          end else if (tmr == LT_END) begin
            tmr <= '0;
            if (attempts == MR) begin
              state <= FAIL;
              outs  <= dec_outs(FAIL);
            end else begin
              state     <= PLL_RST;
              outs      <= dec_outs(PLL_RST);
              attempts  <= attempts + 1'b1;
              retry_cnt <= (retry_cnt == CNT_MAX) ? retry_cnt : retry_cnt + 1'b1;
            end
          end
        end
        STABLE: begin
          // A lock glitch restarts the wait without costing an attempt.
          if (!lk) begin
            state <= WAIT_LOCK;
            outs  <= dec_outs(WAIT_LOCK);
            tmr   <= '0;
          end else if (tmr == LS_END) begin
            state    <= RUN;
            outs     <= dec_outs(RUN);
            tmr      <= '0;
            attempts <= '0;
          end
        end
        RUN: begin
          tmr <= '0;
          if (!lk) begin
            state    <= PLL_RST;
            outs     <= dec_outs(PLL_RST);
            loss_cnt <= (loss_cnt == CNT_MAX) ? loss_cnt : loss_cnt + 1'b1;
          end
        end
        FAIL: begin
          tmr <= '0;
        end
        default: begin
          state <= PLL_RST;
          outs  <= dec_outs(PLL_RST);
          tmr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised bench for pll_reset_sequencer against a deadline-based model of
// the sequencing rules, plus directed latency and counter checks.
module tb_pll_reset_sequencer;

  localparam int RP = 4;
  localparam int LT = 20;
  localparam int LS = 8;
  localparam int MR = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam int M_PULSE  = 10;
  localparam int M_WAIT   = 11;
  localparam int M_STABLE = 12;
  localparam int M_RUN    = 13;
  localparam int M_FAIL   = 14;

  logic          clk_sys = 1'b0;
  logic          rst     = 1'b1;
  logic          core_rst, ready, fail;
  logic [CW-1:0] retry_cnt, loss_cnt;

  pll_reset_sequencer_if pif ();

  always #10 clk_sys = ~clk_sys;

  pll_reset_sequencer #(
    .RST_PULSE    (RP),
    .LOCK_TIMEOUT (LT),
    .LOCK_STABLE  (LS),
    .MAX_RETRY    (MR),
    .CNT_W        (CW)
  ) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .pll       (pif),
    .core_rst  (core_rst),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: phase plus cycles left before the phase's deadline expires
  int         m_ph, m_left, m_att, m_retry, m_loss;
  logic [1:0] m_hist;
  int         hi_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic l);
    logic lk_s;
    if (r) begin
      m_ph = M_PULSE; m_left = RP; m_att = 0; m_retry = 0; m_loss = 0; m_hist = 2'b00;
      return;
    end
    lk_s   = m_hist[1];
    m_hist = {m_hist[0], l};
    case (m_ph)
      M_PULSE: begin
        m_left--;
        if (m_left == 0) begin m_ph = M_WAIT; m_left = LT; end
      end
      M_WAIT: begin
        if (lk_s) begin
          m_ph = M_STABLE; m_left = LS;
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (m_att == MR) m_ph = M_FAIL;
            else begin
              m_att++;
              if (m_retry < CMAX) m_retry++;
              m_ph = M_PULSE; m_left = RP;
            end
          end
        end
      end
      M_STABLE: begin
        if (!lk_s) begin
          m_ph = M_WAIT; m_left = LT;
        end else begin
          m_left--;
          if (m_left == 0) begin m_ph = M_RUN; m_att = 0; end
        end
      end
      M_RUN: begin
        if (!lk_s) begin
          m_ph = M_PULSE; m_left = RP;
          if (m_loss < CMAX) m_loss++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic cyc(input logic r, input logic l);
    rst = r;
    pif.pll_locked = l;
    @(posedge clk_sys);
    model_step(r, l);
    @(negedge clk_sys);
    if (pif.pll_rst === 1'b1) hi_cnt++;
    chk("pll_rst",   pif.pll_rst, m_ph == M_PULSE);
    chk("core_rst",  core_rst,    m_ph != M_RUN);
    chk("ready",     ready,       m_ph == M_RUN);
    chk("fail",      fail,        m_ph == M_FAIL);
    chk("retry_cnt", retry_cnt,   m_retry);
    chk("loss_cnt",  loss_cnt,    m_loss);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    hi_cnt = 0;
    cyc(1'b1, 1'b0);
  endtask

  // Hold lock high until ready; n = cycles with lock driven high.
  task automatic lock_until_ready(input int lim, output int n);
    n = 0;
    do begin
      cyc(1'b0, 1'b1);
      n++;
    end while (ready !== 1'b1 && n < lim);
    chk("reach_run", ready, 1'b1);
  endtask

  initial begin
    int n, r0, len;
    logic lv;
    pif.pll_locked = 1'b0;

    // reset state
    do_reset();
    chk("rst_pll_rst", pif.pll_rst, 1'b1);
    chk("rst_core",    core_rst,    1'b1);
    chk("rst_cnts",    {retry_cnt, loss_cnt}, 0);

    // clean lock
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    chk("pulse_len", hi_cnt, RP);
    lock_until_ready(60, n);
    chk("lock_lat", n - 1, 2 + LS);
    chk("clean_retry", retry_cnt, 0);

    // loss in RUN, repeated to saturate loss_cnt
    for (int k = 0; k < 5; k++) begin
      hi_cnt = 0;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
      chk("loss_core", core_rst, 1'b1);
      chk("loss_ready", ready, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
      if (k == 0) begin
        chk("loss_pulse", hi_cnt, RP);
        chk("loss_cnt1", loss_cnt, 1);
      end
      lock_until_ready(60, n);
    end
    chk("loss_sat", loss_cnt, CMAX);

    // reset while running
    cyc(1'b1, 1'b1);
    chk("mid_pll_rst", pif.pll_rst, 1'b1);
    chk("mid_core", core_rst, 1'b1);
    chk("mid_cnts", {retry_cnt, loss_cnt}, 0);
    cyc(1'b1, 1'b0);

    // timeout retry
    for (int i = 0; i < RP + LT - 1; i++) cyc(1'b0, 1'b0);
    chk("to_pre", pif.pll_rst, 1'b0);
    cyc(1'b0, 1'b0);
    chk("to_pulse", pif.pll_rst, 1'b1);
    chk("to_retry", retry_cnt, 1);
    lock_until_ready(80, n);
    chk("to_run_retry", retry_cnt, 1);

    // glitch in STABLE
    do_reset();
    n = 0;
    while (m_ph != M_STABLE && n < 40) begin cyc(1'b0, 1'b1); n++; end
    chk("gl_stable", m_ph, M_STABLE);
    hi_cnt = 0;
    r0 = retry_cnt;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    lock_until_ready(60, n);
    chk("gl_lat", n - 1, 2 + LS);
    chk("gl_no_pulse", hi_cnt, 0);
    chk("gl_retry", retry_cnt, r0);

    // exhaustion
    do_reset();
    for (int i = 0; i < 3 * (RP + LT) + 5; i++) cyc(1'b0, 1'b0);
    chk("ex_fail", fail, 1'b1);
    chk("ex_pll_rst", pif.pll_rst, 1'b0);
    chk("ex_core", core_rst, 1'b1);
    chk("ex_retry", retry_cnt, MR);
    for (int i = 0; i < 1000; i++) cyc(1'b0, 1'($urandom_range(0, 1)));
    chk("ex_hold", fail, 1'b1);

    // random lock behaviour with occasional resets
    do_reset();
    for (int k = 0; k < 150; k++) begin
      lv  = 1'($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) cyc($urandom_range(0, 199) == 0, lv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
